// File: rtl/gpio_in_debounce_if.sv
// ============================================================================
// gpio_in_debounce_if : pin, level, edge and pending-event signals of the
//                       GPIO input conditioner
// Revision 1.0
// ============================================================================
`default_nettype none

interface gpio_in_debounce_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] pin_in;
    logic [WIDTH-1:0] gpio_clean;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] pending;
    logic             irq;

    modport master (
        output pin_in, rise_en, fall_en, clr_mask,
        input  gpio_clean, rise_pulse, fall_pulse, pending, irq
    );

    modport slave (
        input  pin_in, rise_en, fall_en, clr_mask,
        output gpio_clean, rise_pulse, fall_pulse, pending, irq
    );
endinterface

`default_nettype wire

// File: rtl/gpio_in_debounce.sv
// ============================================================================
// gpio_in_debounce : per-bit synchronizer, debounce filter, edge pulses and
//                    sticky event-pending flags with a single interrupt line
// Revision 1.0
// ============================================================================
`default_nettype none

module gpio_in_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int CNT_W           = 17
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    gpio_in_debounce_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] clean_q, clean_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.pin_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign w_sync = sync_q[SYNC_STAGES-1];

    // Counter saturates at CNT_MAX; reaching it while still mismatched accepts the level.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             accept;

        always_comb begin
            cnt_d  = '0;
            accept = 1'b0;
            if (w_sync[i] != clean_q[i]) begin
                if (cnt_q == CNT_MAX) begin
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign w_accept[i] = accept;
    end

    always_comb begin
        clean_d   = clean_q ^ w_accept;
        rise_d    = w_accept & w_sync;
        fall_d    = w_accept & ~w_sync;
        pending_d = (pending_q & ~bus.clr_mask)
                  | (rise_q & bus.rise_en)
                  | (fall_q & bus.fall_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            pending_q <= '0;
        end else begin
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pending_q <= pending_d;
        end
    end

    assign bus.gpio_clean = clean_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.pending    = pending_q;
    assign bus.irq        = |pending_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_in_debounce.sv
// ============================================================================
// tb_gpio_in_debounce : scoreboarded bench for the GPIO input conditioner
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_gpio_in_debounce;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    gpio_in_debounce_if #(.WIDTH(8)) bus ();

    gpio_in_debounce #(
        .WIDTH           (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int bitn;
        bit rise;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every observed pulse must match the next expected event in order.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.rise_pulse[b] || bus.fall_pulse[b]) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_pulse: bit %0d rise=%0b fall=%0b at cycle %0d, none expected",
                                 b, bus.rise_pulse[b], bus.fall_pulse[b], cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.cyc !== cyc || mon_e.bitn !== b ||
                            mon_e.rise !== bus.rise_pulse[b] || bus.rise_pulse[b] === bus.fall_pulse[b]) begin
                            bad++;
                            $display("FAIL pulse_event: got bit %0d rise=%0b fall=%0b cycle %0d, want bit %0d rise=%0b cycle %0d",
                                     b, bus.rise_pulse[b], bus.fall_pulse[b], cyc,
                                     mon_e.bitn, mon_e.rise, mon_e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_ev(input int c, input int b, input bit r);
        ev_t e;
        e.cyc  = c;
        e.bitn = b;
        e.rise = r;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        cycles(3);
        total++;
        if (bus.gpio_clean !== 8'h00) begin bad++; $display("FAIL reset_clean: got %h want 00", bus.gpio_clean); end
        total++;
        if (bus.rise_pulse !== 8'h00) begin bad++; $display("FAIL reset_rise: got %h want 00", bus.rise_pulse); end
        total++;
        if (bus.fall_pulse !== 8'h00) begin bad++; $display("FAIL reset_fall: got %h want 00", bus.fall_pulse); end
        total++;
        if (bus.pending !== 8'h00) begin bad++; $display("FAIL reset_pending: got %h want 00", bus.pending); end
        total++;
        if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_rise;
        int c0;
        c0 = cyc;
        bus.pin_in[0] = 1'b1;
        push_ev(c0 + 6, 0, 1'b1);
        cycles(5);
        total++;
        if (bus.gpio_clean !== 8'h00) begin bad++; $display("FAIL rise_early: got %h want 00", bus.gpio_clean); end
        cycles(1);
        total++;
        if (bus.gpio_clean !== 8'h01) begin bad++; $display("FAIL rise_latency: got %h want 01", bus.gpio_clean); end
        cycles(1);
        total++;
        if (bus.rise_pulse !== 8'h00) begin bad++; $display("FAIL rise_width: got %h want 00", bus.rise_pulse); end
        cycles(4);
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL rise_missing: got %0d pending events want 0", exp_q.size()); end
        total++;
        if (bus.pending !== 8'h00) begin bad++; $display("FAIL rise_pending: got %h want 00", bus.pending); end
    endtask

    task automatic test_glitch;
        bus.pin_in[1] = 1'b1;
        cycles(3);
        bus.pin_in[1] = 1'b0;
        cycles(10);
        total++;
        if (bus.gpio_clean !== 8'h01) begin bad++; $display("FAIL glitch_clean: got %h want 01", bus.gpio_clean); end
        total++;
        if (bus.pending !== 8'h00) begin bad++; $display("FAIL glitch_pending: got %h want 00", bus.pending); end
    endtask

    task automatic test_pending;
        int c0;
        bus.rise_en = 8'h01;
        c0 = cyc;
        bus.pin_in[0] = 1'b0;
        push_ev(c0 + 6, 0, 1'b0);
        cycles(8);
        total++;
        if (bus.pending !== 8'h00) begin bad++; $display("FAIL pend_fall_masked: got %h want 00", bus.pending); end
        c0 = cyc;
        bus.pin_in[0] = 1'b1;
        push_ev(c0 + 6, 0, 1'b1);
        cycles(6);
        total++;
        if (bus.irq !== 1'b0) begin bad++; $display("FAIL pend_before: got irq %b want 0", bus.irq); end
        cycles(1);
        total++;
        if (bus.pending !== 8'h01) begin bad++; $display("FAIL pend_set: got %h want 01", bus.pending); end
        total++;
        if (bus.irq !== 1'b1) begin bad++; $display("FAIL pend_irq: got %b want 1", bus.irq); end
        bus.clr_mask = 8'h01;
        cycles(1);
        bus.clr_mask = 8'h00;
        total++;
        if (bus.pending !== 8'h00 || bus.irq !== 1'b0) begin
            bad++; $display("FAIL pend_clear: got pending %h irq %b want 00 0", bus.pending, bus.irq);
        end
        bus.rise_en = 8'h00;
    endtask

    task automatic test_set_wins;
        int c0;
        bus.fall_en = 8'h04;
        c0 = cyc;
        bus.pin_in[2] = 1'b1;
        push_ev(c0 + 6, 2, 1'b1);
        cycles(8);
        c0 = cyc;
        bus.pin_in[2] = 1'b0;
        push_ev(c0 + 6, 2, 1'b0);
        cycles(6);
        bus.clr_mask = 8'h04;
        cycles(1);
        total++;
        if (bus.pending !== 8'h04) begin bad++; $display("FAIL set_wins: got %h want 04", bus.pending); end
        cycles(1);
        bus.clr_mask = 8'h00;
        total++;
        if (bus.pending !== 8'h00) begin bad++; $display("FAIL set_wins_clear: got %h want 00", bus.pending); end
        bus.fall_en = 8'h00;
    endtask

    task automatic test_bounce;
        int c0;
        bus.rise_en = 8'h08;
        for (int k = 0; k < 20; k++) begin
            bus.pin_in[3] = (k % 2 == 0);
            cycles(2);
        end
        c0 = cyc;
        bus.pin_in[3] = 1'b1;
        push_ev(c0 + 6, 3, 1'b1);
        cycles(10);
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL bounce_missing: got %0d pending events want 0", exp_q.size()); end
        total++;
        if (bus.gpio_clean !== 8'h09) begin bad++; $display("FAIL bounce_clean: got %h want 09", bus.gpio_clean); end
        total++;
        if (bus.pending !== 8'h08) begin bad++; $display("FAIL bounce_pending: got %h want 08", bus.pending); end
    endtask

    task automatic test_reset_mid;
        int r;
        bus.pin_in[4] = 1'b1;
        cycles(4);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.gpio_clean !== 8'h00 || bus.rise_pulse !== 8'h00 || bus.fall_pulse !== 8'h00) begin
            bad++; $display("FAIL rstmid_outputs: got clean %h rise %h fall %h want 00 00 00",
                            bus.gpio_clean, bus.rise_pulse, bus.fall_pulse);
        end
        total++;
        if (bus.pending !== 8'h00 || bus.irq !== 1'b0) begin
            bad++; $display("FAIL rstmid_pending: got %h irq %b want 00 0", bus.pending, bus.irq);
        end
        bus.rise_en = 8'h10;
        cycles(1);
        rst_n = 1'b1;
        r = cyc;
        push_ev(r + 6, 0, 1'b1);
        push_ev(r + 6, 3, 1'b1);
        push_ev(r + 6, 4, 1'b1);
        cycles(5);
        total++;
        if (bus.gpio_clean !== 8'h00) begin bad++; $display("FAIL rstmid_early: got %h want 00", bus.gpio_clean); end
        cycles(1);
        total++;
        if (bus.gpio_clean !== 8'h19) begin bad++; $display("FAIL rstmid_clean: got %h want 19", bus.gpio_clean); end
        cycles(1);
        total++;
        if (bus.pending !== 8'h10 || bus.irq !== 1'b1) begin
            bad++; $display("FAIL rstmid_pend: got %h irq %b want 10 1", bus.pending, bus.irq);
        end
        cycles(3);
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL rstmid_missing: got %0d pending events want 0", exp_q.size()); end
    endtask

    initial begin
        bus.pin_in   = 8'h00;
        bus.rise_en  = 8'h00;
        bus.fall_en  = 8'h00;
        bus.clr_mask = 8'h00;
        test_reset;
        test_rise;
        test_glitch;
        test_pending;
        test_set_wins;
        test_bounce;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
